// File: rtl/mix_cols_seq.sv
// Sequential AES MixColumns engine, COLS_PER_CYCLE columns per clock.
// Define MIX_COLS_INV_EN to compile in InvMixColumns selected by inv.
module mix_cols_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // in_valid/in_ready and out_valid/out_ready: a transfer happens on a rising
  // edge where both are high; out_state stays stable while out_valid waits.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  state_e         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [2:0]     cnt_sum;
  logic [1:0]     col;
  logic [31:0]    col_src;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = c;
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2),
            a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
  endfunction

`ifdef MIX_COLS_INV_EN
  logic inv_q, inv_d;

  // InvMixColumns = MixColumns applied after this cheap pre-mix.
  function automatic logic [31:0] inv_pre(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, u, v;
    {a0, a1, a2, a3} = c;
    u = xt(xt(a0 ^ a2));
    v = xt(xt(a1 ^ a3));
    return {a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v};
  endfunction
`else
  logic unused_inv;
  assign unused_inv = inv;
`endif

  assign cnt_sum = {1'b0, cnt_q} + STEP;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    col     = '0;
    col_src = '0;
`ifdef MIX_COLS_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MIX_COLS_INV_EN
          inv_d   = inv;
`endif
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          col = cnt_q + 2'(j);
          // Column 0 sits in the top word, so word offset is 3-col = ~col.
          col_src = work_q[{~col, 5'd0} +: 32];
`ifdef MIX_COLS_INV_EN
          if (inv_q) col_src = inv_pre(col_src);
`endif
          work_d[{~col, 5'd0} +: 32] = mix_fwd(col_src);
        end
        cnt_d = cnt_sum[1:0];
        if (cnt_sum[2]) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
`ifdef MIX_COLS_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
`ifdef MIX_COLS_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign out_state = (state_q == DONE) ? work_q : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mix_cols_seq.sv
// Bench for mix_cols_seq: one instance at 1 column/cycle, one at 4 columns/cycle.
module tb_mix_cols_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   in_valid, in_ready, inv, out_valid, out_ready, busy;
  logic [127:0] in_state [2];
  logic [127:0] out_state [2];
  logic [1:0]   state_dbg [2];

  int total  = 0;
  int passed = 0;

  mix_cols_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .inv(inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]),
    .state_dbg(state_dbg[0])
  );

  mix_cols_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .inv(inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]),
    .state_dbg(state_dbg[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: GF(2^8) shift-and-add multiply and a coefficient-matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic iv);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (iv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - row + 4) % 4], a[j]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_of(input logic [127:0] s, input logic iv);
`ifdef MIX_COLS_INV_EN
    return mix_ref(s, iv);
`else
    return mix_ref(s, 1'b0);
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle(input int u, input string tag);
    chk({tag, ":in_ready"}, in_ready[u], 1);
    chk({tag, ":out_valid"}, out_valid[u], 0);
    chk({tag, ":busy"}, busy[u], 0);
    chk({tag, ":out_state"}, out_state[u], 0);
  endtask

  // One full transaction on unit u; hold = cycles of out_ready low in DONE.
  task automatic run_op(input int u, input logic [127:0] st, input logic iv,
                        input logic [127:0] exp, input int hold, input string tag);
    int n;
    int lat;
    logic [127:0] held;
    lat = (u == 0) ? 4 : 1;
    n = 0;
    while (in_ready[u] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ":ready_wait"}, in_ready[u], 1);
    in_state[u]  = st;
    inv[u]       = iv;
    in_valid[u]  = 1'b1;
    out_ready[u] = (hold == 0);
    @(posedge clk); #1;
    in_valid[u] = 1'($urandom);
    inv[u]      = 1'($urandom);
    in_state[u] = rand128();
    n = 0;
    while (out_valid[u] !== 1'b1 && n < 20) begin
      chk({tag, ":busy_out_zero"}, out_state[u], 0);
      chk({tag, ":busy_flag"}, busy[u], 1);
      chk({tag, ":busy_in_ready"}, in_ready[u], 0);
      @(posedge clk); #1; n++;
    end
    chk({tag, ":latency"}, n, lat);
    chk({tag, ":result"}, out_state[u], exp);
    held = out_state[u];
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, ":bp_stable"}, out_state[u], held);
      chk({tag, ":bp_in_ready"}, in_ready[u], 0);
      chk({tag, ":bp_valid"}, out_valid[u], 1);
    end
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    check_idle(u, {tag, ":release"});
  endtask

  initial begin
    logic [127:0] s;
    logic iv;
    int u;
    rst = 1'b1;
    in_valid = '0;
    inv = '0;
    out_ready = '0;
    in_state[0] = '0;
    in_state[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "reset_c1");
    check_idle(1, "reset_c4");
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
           128'h8e4da1bc9fdc589d01010101c6c6c6c6, 0, "fwd_c1");
    run_op(1, 128'hd4d4d4d52d26314c01010101c6c6c6c6, 1'b0,
           128'hd5d5d7d64d7ebdf801010101c6c6c6c6, 0, "fwd_c4");
`ifdef MIX_COLS_INV_EN
    run_op(0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1,
           128'hdb135345f20a225c01010101c6c6c6c6, 0, "inv_c1");
    run_op(1, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1,
           128'hdb135345f20a225c01010101c6c6c6c6, 0, "inv_c4");
`else
    run_op(0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1,
           mix_ref(128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b0), 0, "inv_off_c1");
    run_op(1, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1,
           mix_ref(128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b0), 0, "inv_off_c4");
`endif

    s = rand128();
    run_op(0, s, 1'b0, exp_of(s, 1'b0), 10, "bp_c1");
    s = rand128();
    run_op(1, s, 1'b1, exp_of(s, 1'b1), 10, "bp_c4");

    // Reset two cycles into a 1-column operation.
    @(negedge clk);
    in_state[0] = rand128();
    inv[0] = 1'b1;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle(0, "rst_busy_c1");
    check_idle(1, "rst_busy_c4");
    @(negedge clk);
    rst = 1'b0;
    s = 128'hdb135345f20a225c01010101c6c6c6c6;
    run_op(0, s, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 0, "after_rst_c1");

    for (int k = 0; k < 16; k++) begin
      u  = int'($urandom_range(0, 1));
      s  = rand128();
      iv = 1'($urandom);
      run_op(u, s, iv, exp_of(s, iv), int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mix_cols_seq.md
MIX_COLS_SEQ -- requirements
Module: mix_cols_seq

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, meaning columns transformed per clock; legal values 1, 2, 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  in_state/inv valid this cycle.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 in_state  input  128  AES state; column 0 = [127:96], byte 0 of each column is its most significant byte.
REQ-007 inv  input  1  1 = InvMixColumns, 0 = MixColumns; sampled with in_state.
REQ-008 out_valid  output  1  out_state holds a completed result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_state  output  128  transformed state, same column and byte order as in_state.
REQ-011 busy  output  1  high in BUSY or DONE.

Function
REQ-012 FSM states IDLE, BUSY, DONE; the FSM is in IDLE after reset.
REQ-013 in_ready = 1 only in IDLE; an accept is in_valid & in_ready at a rising edge.
REQ-014 On accept: register in_state and inv, clear the column counter, and go to BUSY.
REQ-015 In BUSY, each cycle replaces COLS_PER_CYCLE columns, starting at column counter value c and ascending, with their transform in the working register; then c += COLS_PER_CYCLE.
REQ-016 Forward transform per column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3; all multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-017 Inverse transform uses the same row rotation with coefficients 0E, 0B, 0D, 09 in place of 2, 3, 1, 1.
REQ-018 BUSY lasts N = 4/COLS_PER_CYCLE cycles; after the last column the FSM goes to DONE.
REQ-019 With an accept at edge k, out_valid rises after edge k+N; latency is 4, 2 or 1 cycles.
REQ-020 In DONE: out_valid = 1 and out_state is stable until out_valid & out_ready at an edge, after which the FSM returns to IDLE.
REQ-021 out_ready held low applies unlimited backpressure: no state change and no new accept occur.
REQ-022 out_state shows the working register only in DONE and is zero in IDLE and BUSY.
REQ-023 in_valid and inv are ignored outside IDLE; mode cannot change mid-operation.
REQ-024 The column counter is 2 bits and wraps to 0 on completion; no out-of-range column is ever addressed.

Reset
REQ-025 Asserting rst at any time, including mid-BUSY or mid-DONE, immediately forces IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, column counter=0, and stored mode=0.
REQ-026 A partially processed state is discarded on reset and never emitted.
REQ-027 The first accept is possible at the first rising edge after rst deasserts.

Configuration
REQ-028 Macro MIX_COLS_INV_EN: when defined, the inverse datapath is compiled in and inv selects the mode per REQ-017.
REQ-029 When MIX_COLS_INV_EN is undefined, no inverse logic exists, inv is ignored, and every operation is forward MixColumns.

Verification
REQ-030 Bench shall cover these scenarios:
- Forward, COLS_PER_CYCLE=1: columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6; out_valid 4 cycles after accept.
- Forward, COLS_PER_CYCLE=4: columns d4d4d4d5, 2d26314c, 01010101, c6c6c6c6 -> d5d5d7d6, 4d7ebdf8, 01010101, c6c6c6c6; latency 1.
- Inverse, MIX_COLS_INV_EN defined: 8e4da1bc9fdc589d01010101c6c6c6c6 -> db135345f20a225c01010101c6c6c6c6; with the macro undefined and inv=1, the forward result is produced.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0; release -> IDLE the next cycle.
- Reset mid-BUSY (COLS_PER_CYCLE=1, after 2 cycles): outputs at reset values at once; the next accept yields the correct result with no stale columns.
